// File: rtl/msrv32_lsu_ctrl.sv
// Load/store control for the msrv32 pipeline: runs each data-memory access as a req/ack
// handshake with store lane formatting, load extension, misalignment rejection and bus timeout.
module msrv32_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        ld_req_in,
  input  logic        st_req_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs_2_in,
  output logic        dm_req_out,
  output logic        dm_we_out,
  output logic [31:0] dm_addr_out,
  output logic [31:0] dm_wdata_out,
  output logic [3:0]  dm_wmask_out,
  input  logic        dm_ack_in,
  input  logic [31:0] dm_rdata_in,
  output logic        stall_out,
  output logic [31:0] ld_data_out,
  output logic        ld_valid_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              ld_valid_q, ld_valid_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;

  logic              accept, mis_now;
  logic [31:0]       fmt_wdata;
  logic [3:0]        fmt_wmask;
  logic [31:0]       rd_byte_sh, rd_half_sh, ld_ext;

  // Request decode and store formatting from the live upstream inputs.
  always_comb begin
    accept = (state_q != StReq) && (ld_req_in || st_req_in);
    unique case (load_size_in)
      2'b00:   mis_now = 1'b0;
      2'b01:   mis_now = iadder_in[0];
      default: mis_now = |iadder_in[1:0];
    endcase
    unique case (load_size_in)
      2'b00: begin
        fmt_wdata = {4{rs_2_in[7:0]}};
        fmt_wmask = 4'b0001 << iadder_in[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{rs_2_in[15:0]}};
        fmt_wmask = 4'b0011 << iadder_in[1:0];
      end
      default: begin
        fmt_wdata = rs_2_in;
        fmt_wmask = 4'b1111;
      end
    endcase
    if (!st_req_in) fmt_wmask = 4'b0000;
  end

  // Load extension uses the attributes captured at accept time.
  always_comb begin
    rd_byte_sh = dm_rdata_in >> {addr_q[1:0], 3'b000};
    rd_half_sh = dm_rdata_in >> {addr_q[1], 4'b0000};
    unique case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & rd_byte_sh[7]}}, rd_byte_sh[7:0]};
      2'b01:   ld_ext = {{16{~uns_q & rd_half_sh[15]}}, rd_half_sh[15:0]};
      default: ld_ext = dm_rdata_in;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          if (mis_now) begin
            mis_d = 1'b1;
          end else begin
            state_d = StReq;
            cnt_d   = '0;
            addr_d  = iadder_in;
            size_d  = load_size_in;
            uns_d   = load_unsigned_in;
            we_d    = st_req_in;
            wdata_d = fmt_wdata;
            wmask_d = fmt_wmask;
          end
        end
      end
      StReq: begin
        // An ack in the final timeout cycle still completes the access normally.
        if (dm_ack_in) begin
          state_d = StDone;
          if (!we_q) begin
            ld_data_d  = ld_ext;
            ld_valid_d = 1'b1;
          end
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StDone;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
    end
  end

  always_comb begin
    dm_req_out     = (state_q == StReq);
    dm_we_out      = we_q;
    dm_addr_out    = {addr_q[31:2], 2'b00};
    dm_wdata_out   = wdata_q;
    dm_wmask_out   = wmask_q;
    stall_out      = (accept && !mis_now) || (state_q == StReq);
    ld_data_out    = ld_data_q;
    ld_valid_out   = ld_valid_q;
    misaligned_out = mis_q;
    bus_err_out    = berr_q;
  end

endmodule

// File: tb/tb_msrv32_lsu_ctrl.sv
// Directed bench for msrv32_lsu_ctrl: table of single accesses plus reset-abort and
// back-to-back sequences.
module tb_msrv32_lsu_ctrl;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_req = 1'b0, st_req = 1'b0, uns = 1'b0, ack = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, rs2 = '0, rdata = '0;
  logic        dm_req, dm_we, stall, ld_valid, mis, berr;
  logic [31:0] dm_addr, dm_wdata, ld_data;
  logic [3:0]  dm_wmask;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_ld = '0;

  msrv32_lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .ld_req_in            (ld_req),
    .st_req_in            (st_req),
    .load_size_in         (size),
    .load_unsigned_in     (uns),
    .iadder_in            (addr),
    .rs_2_in              (rs2),
    .dm_req_out           (dm_req),
    .dm_we_out            (dm_we),
    .dm_addr_out          (dm_addr),
    .dm_wdata_out         (dm_wdata),
    .dm_wmask_out         (dm_wmask),
    .dm_ack_in            (ack),
    .dm_rdata_in          (rdata),
    .stall_out            (stall),
    .ld_data_out          (ld_data),
    .ld_valid_out         (ld_valid),
    .misaligned_out       (mis),
    .bus_err_out          (berr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld, st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, rs2, rdata;
    int          waits;       // wait cycles before ack; >= T means never ack
    logic        misal;
    logic [31:0] exp_ld;      // expected ld_data for a completing load
    logic [31:0] exp_wdata;
    logic [3:0]  exp_mask;
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input vec_t v, input int idx);
    int reqc, stallc;
    logic acked, is_st;
    is_st = v.st;
    @(negedge clk);
    ld_req = v.ld; st_req = v.st; size = v.size; uns = v.uns;
    addr = v.addr; rs2 = v.rs2; rdata = v.rdata; ack = 1'b0;
    #1;
    chk($sformatf("v%0d accept stall", idx), {31'b0, stall}, {31'b0, ~v.misal});
    stallc = stall ? 1 : 0;
    if (v.misal) begin
      @(negedge clk); ld_req = 0; st_req = 0; #1;
      chk($sformatf("v%0d misaligned pulse", idx), {31'b0, mis}, 32'd1);
      chk($sformatf("v%0d no dm_req", idx), {31'b0, dm_req}, 32'd0);
      chk($sformatf("v%0d stall after misal", idx), {31'b0, stall}, 32'd0);
      @(negedge clk); #1;
      chk($sformatf("v%0d misaligned width", idx), {31'b0, mis}, 32'd0);
      return;
    end
    reqc = 0; acked = 1'b0;
    for (int i = 0; i < T && !acked; i++) begin
      @(negedge clk);
      ack = (i == v.waits);
      #1;
      reqc++;
      if (stall) stallc++;
      chk($sformatf("v%0d dm_req", idx), {31'b0, dm_req}, 32'd1);
      chk($sformatf("v%0d dm_addr", idx), dm_addr, v.addr & 32'hFFFF_FFFC);
      chk($sformatf("v%0d dm_we", idx), {31'b0, dm_we}, {31'b0, is_st});
      chk($sformatf("v%0d dm_wmask", idx), {28'b0, dm_wmask}, {28'b0, v.exp_mask});
      if (is_st) chk($sformatf("v%0d dm_wdata", idx), dm_wdata, v.exp_wdata);
      acked = ack;
    end
    @(negedge clk);
    ack = 1'b0; ld_req = 0; st_req = 0;
    #1;
    if (!is_st && acked) last_ld = v.exp_ld;
    chk($sformatf("v%0d req cycles", idx), reqc, (v.waits < T) ? v.waits + 1 : T);
    chk($sformatf("v%0d stall cycles", idx), stallc, (v.waits < T) ? v.waits + 2 : T + 1);
    chk($sformatf("v%0d done dm_req", idx), {31'b0, dm_req}, 32'd0);
    chk($sformatf("v%0d done stall", idx), {31'b0, stall}, 32'd0);
    chk($sformatf("v%0d ld_valid", idx), {31'b0, ld_valid}, {31'b0, !is_st && acked});
    chk($sformatf("v%0d bus_err", idx), {31'b0, berr}, {31'b0, !acked});
    chk($sformatf("v%0d ld_data", idx), ld_data, last_ld);
    @(negedge clk); #1;
    chk($sformatf("v%0d pulse end", idx), {30'b0, ld_valid, berr}, 32'd0);
  endtask

  initial begin
    //          ld st size  uns addr           rs2            rdata          w  mis exp_ld         wdata          mask
    vecs[0]  = '{1, 0, 2'b00, 0, 32'h0000_1003, 32'h0,         32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 32'h0,         4'b0000};
    vecs[1]  = '{1, 0, 2'b01, 1, 32'h0000_2002, 32'h0,         32'hBEEF_0000, 0, 0, 32'h0000_BEEF, 32'h0,         4'b0000};
    vecs[2]  = '{0, 1, 2'b00, 0, 32'h0000_3001, 32'h1234_5678, 32'h0,         3, 0, 32'h0,         32'h7878_7878, 4'b0010};
    vecs[3]  = '{1, 0, 2'b10, 0, 32'h0000_4002, 32'h0,         32'h0,         0, 1, 32'h0,         32'h0,         4'b0000};
    vecs[4]  = '{0, 1, 2'b01, 0, 32'h0000_4002, 32'h0000_ABCD, 32'h0,         1, 0, 32'h0,         32'hABCD_ABCD, 4'b1100};
    vecs[5]  = '{1, 0, 2'b10, 0, 32'h0000_5000, 32'h0,         32'h5555_5555, 9, 0, 32'h0,         32'h0,         4'b0000};
    vecs[6]  = '{1, 0, 2'b10, 0, 32'h0000_5000, 32'h0,         32'h1122_3344, 3, 0, 32'h1122_3344, 32'h0,         4'b0000};
    vecs[7]  = '{1, 0, 2'b01, 0, 32'h0000_6000, 32'h0,         32'h0000_8001, 0, 0, 32'hFFFF_8001, 32'h0,         4'b0000};
    vecs[8]  = '{1, 0, 2'b00, 1, 32'h0000_7001, 32'h0,         32'h0000_A500, 2, 0, 32'h0000_00A5, 32'h0,         4'b0000};
    vecs[9]  = '{0, 1, 2'b10, 0, 32'h0000_8000, 32'hDEAD_BEEF, 32'h0,         0, 0, 32'h0,         32'hDEAD_BEEF, 4'b1111};
    vecs[10] = '{1, 0, 2'b11, 0, 32'h0000_9000, 32'h0,         32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 32'h0,         4'b0000};
    vecs[11] = '{1, 1, 2'b01, 0, 32'h0000_9001, 32'h0,         32'h0,         0, 1, 32'h0,         32'h0,         4'b0000};

    #1;
    chk("reset outputs", {dm_req, dm_we, stall, ld_valid, mis, berr}, 6'b0);
    chk("reset ld_data", ld_data, 32'h0);
    chk("reset dm_addr", dm_addr, 32'h0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset in the middle of a stalled load.
    @(negedge clk);
    ld_req = 1; size = 2'b10; uns = 0; addr = 32'h0000_B000; ack = 0;
    @(negedge clk); #1;
    chk("rst seq dm_req", {31'b0, dm_req}, 32'd1);
    rst = 1'b1; #1;
    chk("rst seq flags", {dm_req, dm_we, ld_valid, mis, berr}, 5'b0);
    chk("rst seq addr", dm_addr, 32'h0);
    chk("rst seq wdata/mask", {dm_wdata[27:0], dm_wmask}, 32'h0);
    chk("rst seq ld_data", ld_data, 32'h0);
    ld_req = 0; #1;
    chk("rst seq stall", {31'b0, stall}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rst seq no ld_valid", {30'b0, ld_valid, dm_req}, 32'd0);
    end

    // Store then load presented in the store's DONE cycle.
    @(negedge clk);
    st_req = 1; size = 2'b10; addr = 32'h0000_A000; rs2 = 32'h0102_0304; #1;
    chk("b2b store stall", {31'b0, stall}, 32'd1);
    @(negedge clk); ack = 1; #1;
    chk("b2b store req", {dm_req, dm_we}, 2'b11);
    @(negedge clk);
    ack = 0; st_req = 0; ld_req = 1; size = 2'b00; uns = 1; addr = 32'h0000_A002; #1;
    chk("b2b done accept stall", {31'b0, stall}, 32'd1);
    chk("b2b done no req", {31'b0, dm_req}, 32'd0);
    @(negedge clk); ack = 1; rdata = 32'h005A_0000; #1;
    chk("b2b load req", {dm_req, dm_we}, 2'b10);
    chk("b2b load addr", dm_addr, 32'h0000_A000);
    chk("b2b load mask", {28'b0, dm_wmask}, 32'h0);
    @(negedge clk); ack = 0; ld_req = 0; #1;
    chk("b2b ld_valid", {31'b0, ld_valid}, 32'd1);
    chk("b2b ld_data", ld_data, 32'h0000_005A);
    chk("b2b stall end", {31'b0, stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv32_lsu_ctrl.md
# msrv32_lsu_ctrl

Load/store control unit for the msrv32 pipeline. It sits directly downstream of the stage-2 pipeline register and consumes its registered `iadder`, `rs_2`, `load_size` and `load_unsigned` outputs. It runs each data-memory access as a req/ack handshake, stalls the pipeline while an access is in flight, and handles byte-lane store alignment, load extension, misalignment detection and a bus timeout.

## Interface
- TIMEOUT_CYCLES, 16: maximum REQ-state cycles without `dm_ack_in` before a bus error is reported (≥2).
- ms_riscv32_mp_clk_in  in  1  clock; all state changes on the rising edge.
- ms_riscv32_mp_rst_in  in  1  reset; asynchronous, active-high.
- ld_req_in  in  1  execute-stage instruction is a load.
- st_req_in  in  1  execute-stage instruction is a store; wins if asserted together with ld_req_in.
- load_size_in  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- load_unsigned_in  in  1  zero-extend loads when 1, sign-extend when 0.
- iadder_in  in  32  effective address.
- rs_2_in  in  32  store data.
- dm_req_out  out  1  memory request.
- dm_we_out  out  1  1 = write.
- dm_addr_out  out  32  word address, `{addr[31:2],2'b00}`.
- dm_wdata_out  out  32  lane-replicated store data.
- dm_wmask_out  out  4  byte write enables; 0000 on loads.
- dm_ack_in  in  1  memory accepted/completed the access this cycle.
- dm_rdata_in  in  32  read data, valid with dm_ack_in.
- stall_out  out  1  pipeline hold (combinational).
- ld_data_out  out  32  extended load result.
- ld_valid_out  out  1  one-cycle pulse: ld_data_out is valid.
- misaligned_out  out  1  one-cycle pulse: access rejected as misaligned.
- bus_err_out  out  1  one-cycle pulse: access timed out.

## Operation
- States: IDLE, REQ, DONE. DONE accepts a new request exactly as IDLE does, so back-to-back accesses are supported.
- Accept (IDLE/DONE with ld_req_in|st_req_in):
  - Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
  - If misaligned: misaligned_out is high the next cycle, no bus access, and the next state is IDLE.
  - Otherwise: register the address, size, unsigned flag, we, wdata and mask, and go to REQ.
- REQ: dm_req_out=1, with address, we, wdata and mask held stable.
  - On dm_ack_in, go to DONE. For a load, capture the extended dm_rdata_in into ld_data_out and assert ld_valid_out in DONE.
  - Timeout counter: cleared on entry to REQ, increments each REQ cycle without ack. At count = TIMEOUT_CYCLES-1 with no ack, go to DONE with bus_err_out=1 and ld_valid_out=0. An ack in that same cycle wins over the timeout.
- Store formatting, with lane = addr[1:0]:
  - byte: wdata = {4{rs2[7:0]}}, mask = 0001<<lane.
  - half: wdata = {2{rs2[15:0]}}, mask = 0011<<lane.
  - word: wdata = rs2, mask = 1111.
- Load extension:
  - byte: rdata[8·lane+7 : 8·lane].
  - half: rdata[16·addr[1]+15 : 16·addr[1]].
  - word: all 32 bits.
  - Byte and half results are sign- or zero-extended per load_unsigned.
- stall_out = (accepting an aligned request in IDLE/DONE) | (state==REQ).
- Upstream holds its request inputs stable while stall_out=1. Requests are not re-sampled in REQ.
- Reset (async, also mid-REQ): state=IDLE and counter=0. All outputs go to 0 immediately: dm_req, dm_we, dm_addr, dm_wdata, dm_wmask, ld_data, ld_valid, misaligned, bus_err. stall_out also reads 0 once inputs are idle. An aborted access produces no ld_valid_out.

## Timing
- Zero-wait memory (ack in the first REQ cycle):
  - cycle 0: accept, stall_out=1.
  - cycle 1: dm_req_out=1, stall_out=1, ack.
  - cycle 2: DONE, with ld_valid_out/ld_data_out for a load; stall_out=0.
- Each wait cycle without ack adds one cycle to both REQ and stall.
- Stores have the same latency. DONE is reached without ld_valid_out.
- misaligned_out and bus_err_out are registered pulses of exactly one cycle. ld_valid_out is also exactly one cycle and is never asserted together with bus_err_out.
- ld_data_out holds its value until the next load completes.

## Test plan
- Signed load byte, addr 0x0000_1003, ack in the first REQ cycle with rdata 0x80FF_1234 -> dm_addr 0x0000_1000, dm_wmask 0000, ld_data 0xFFFF_FF80, ld_valid at cycle 2.
- Unsigned load half, addr 0x0000_2002, rdata 0xBEEF_0000 -> ld_data 0x0000_BEEF.
- Store byte, addr 0x0000_3001, rs2 0x1234_5678, ack after 3 wait cycles -> dm_we 1, wdata 0x7878_7878, mask 0010, stall_out high for exactly 5 cycles, no ld_valid.
- Load word at addr 0x0000_4002 -> no dm_req, misaligned_out pulse in cycle 1, stall_out never high. Then store half at 0x0000_4002 -> mask 1100.
- TIMEOUT_CYCLES=4, load with ack never asserted -> dm_req high for 4 cycles, bus_err pulse in DONE, ld_valid 0. A repeat run with ack in the 4th REQ cycle -> ld_valid and no bus_err.
- Assert reset during REQ -> dm_req_out and all outputs 0 immediately, no ld_valid after release. Separately, a load presented in the DONE cycle of a store is accepted without an idle gap.
